// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle FSM and the datapath/memory.
// The master side is the control FSM; the slave side is the datapath (or a bench).
interface multicycle_control_if;
  logic [5:0] i_opcode;
  logic       i_memReady;
  logic       o_pcWrite;
  logic       o_pcWriteCond;
  logic [1:0] o_pcSource;
  logic       o_iorD;
  logic       o_memRead;
  logic       o_memWrite;
  logic       o_irWrite;
  logic       o_regDst;
  logic       o_memToReg;
  logic       o_regWrite;
  logic       o_aluSrcA;
  logic [1:0] o_aluSrcB;
  logic [1:0] o_aluOp;
  logic       o_instrDone;
  logic       o_illegal;
  logic [3:0] o_state;

  modport master (
    input  i_opcode, i_memReady,
    output o_pcWrite, o_pcWriteCond, o_pcSource, o_iorD, o_memRead, o_memWrite, o_irWrite,
           o_regDst, o_memToReg, o_regWrite, o_aluSrcA, o_aluSrcB, o_aluOp, o_instrDone,
           o_illegal, o_state
  );

  modport slave (
    output i_opcode, i_memReady,
    input  o_pcWrite, o_pcWriteCond, o_pcSource, o_iorD, o_memRead, o_memWrite, o_irWrite,
           o_regDst, o_memToReg, o_regWrite, o_aluSrcA, o_aluSrcB, o_aluOp, o_instrDone,
           o_illegal, o_state
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS core: fetch, decode, execute, memory,
// writeback, with wait states on a shared memory ready handshake.
module multicycle_control (
  input logic                   i_clk,
  input logic                   i_rst,
  multicycle_control_if.master  bus
);

  localparam logic [5:0] OpR    = 6'h00;
  localparam logic [5:0] OpLw   = 6'h23;
  localparam logic [5:0] OpSw   = 6'h2B;
  localparam logic [5:0] OpBeq  = 6'h04;
  localparam logic [5:0] OpJ    = 6'h02;
  localparam logic [5:0] OpAddi = 6'h08;

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StMemAdr = 4'd3,
    StMemRd  = 4'd4,
    StMemWb  = 4'd5,
    StMemWr  = 4'd6,
    StExec   = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9,
    StJump   = 4'd10,
    StAddiEx = 4'd11,
    StAddiWb = 4'd12
  } state_e;

  // Moore part of the control word; memReady-gated terms are added on the way out.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       done;
  } ctrl_t;

  state_e     state_q, state_d;
  ctrl_t      ctrl_q;
  logic [5:0] op_q;
  logic       legal;
  logic       in_decode;
  logic       fetch_done;

  function automatic ctrl_t ctrl_of(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      StFetch: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      StDecode: c.alu_src_b = 2'b11;
      StMemAdr, StAddiEx: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      StMemRd: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      StMemWr: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      StMemWb: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.done       = 1'b1;
      end
      StExec: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      StAluWb: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        c.done      = 1'b1;
      end
      StAddiWb: begin
        c.reg_write = 1'b1;
        c.done      = 1'b1;
      end
      StBranch: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
        c.done          = 1'b1;
      end
      StJump: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
        c.done      = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Opcode legality, only meaningful while in DECODE.
  always_comb begin
    legal = 1'b0;
    case (bus.i_opcode)
      OpR, OpLw, OpSw, OpBeq, OpJ, OpAddi: legal = 1'b1;
      default:                             legal = 1'b0;
    endcase
  end

  // Next-state logic; unused codes fall back to IDLE.
  always_comb begin
    state_d = StIdle;
    case (state_q)
      StIdle:   state_d = StFetch;
      StFetch:  state_d = bus.i_memReady ? StDecode : StFetch;
      StDecode: begin
        case (bus.i_opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpR:        state_d = StExec;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
          OpAddi:     state_d = StAddiEx;
          default:    state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = (op_q == OpLw) ? StMemRd : StMemWr;
      StMemRd:  state_d = bus.i_memReady ? StMemWb : StMemRd;
      StMemWr:  state_d = bus.i_memReady ? StFetch : StMemWr;
      StExec:   state_d = StAluWb;
      StAddiEx: state_d = StAddiWb;
      StMemWb, StAluWb, StAddiWb, StBranch, StJump: state_d = StFetch;
      default:  state_d = StIdle;
    endcase
  end

  // State, registered control word and opcode latch (captured in DECODE for MEMADR).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      ctrl_q  <= '0;
      op_q    <= 6'h00;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_of(state_d);
      if (state_q == StDecode) op_q <= bus.i_opcode;
    end
  end

  assign in_decode  = (state_q == StDecode);
  assign fetch_done = (state_q == StFetch) && bus.i_memReady;

  assign bus.o_pcWrite     = ctrl_q.pc_write | fetch_done;
  assign bus.o_pcWriteCond = ctrl_q.pc_write_cond;
  assign bus.o_pcSource    = ctrl_q.pc_source;
  assign bus.o_iorD        = ctrl_q.iord;
  assign bus.o_memRead     = ctrl_q.mem_read;
  assign bus.o_memWrite    = ctrl_q.mem_write;
  assign bus.o_irWrite     = fetch_done;
  assign bus.o_regDst      = ctrl_q.reg_dst;
  assign bus.o_memToReg    = ctrl_q.mem_to_reg;
  assign bus.o_regWrite    = ctrl_q.reg_write;
  assign bus.o_aluSrcA     = ctrl_q.alu_src_a;
  assign bus.o_aluSrcB     = ctrl_q.alu_src_b;
  assign bus.o_aluOp       = ctrl_q.alu_op;
  assign bus.o_illegal     = in_decode & ~legal;
  // A store finishes on the cycle memory accepts it; an illegal op finishes in DECODE.
  assign bus.o_instrDone   = ctrl_q.done | ((state_q == StMemWr) & bus.i_memReady) |
                             (in_decode & ~legal);
  assign bus.o_state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each stimulus step pushes the expected
// state and control word for its cycle; a monitor pops and compares on negedge.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst = 1'b1;

  multicycle_control_if bus ();

  multicycle_control dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [21:0] exp;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Expected {state, pcWrite, pcWriteCond, pcSource, iorD, memRead, memWrite, irWrite,
  // regDst, memToReg, regWrite, aluSrcA, aluSrcB, aluOp, instrDone, illegal}.
  function automatic logic [21:0] expect_vec(input logic [3:0] st, input logic mr,
                                             input logic [5:0] op);
    logic pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw, asa, done, ill;
    logic [1:0] psrc, asb, aop;
    pcw = 0; pcwc = 0; iord = 0; mrd = 0; mwr = 0; irw = 0; rdst = 0; m2r = 0;
    rw = 0; asa = 0; done = 0; ill = 0; psrc = 2'b00; asb = 2'b00; aop = 2'b00;
    case (st)
      4'd1: begin mrd = 1; asb = 2'b01; pcw = mr; irw = mr; end
      4'd2: begin
        asb = 2'b11;
        if (!(op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 ||
              op == 6'h02 || op == 6'h08)) begin
          ill = 1; done = 1;
        end
      end
      4'd3, 4'd11: begin asa = 1; asb = 2'b10; end
      4'd4: begin mrd = 1; iord = 1; end
      4'd5: begin m2r = 1; rw = 1; done = 1; end
      4'd6: begin mwr = 1; iord = 1; done = mr; end
      4'd7: begin asa = 1; aop = 2'b10; end
      4'd8: begin rdst = 1; rw = 1; done = 1; end
      4'd9: begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; done = 1; end
      4'd10: begin pcw = 1; psrc = 2'b10; done = 1; end
      4'd12: begin rw = 1; done = 1; end
      default: ;
    endcase
    return {st, pcw, pcwc, psrc, iord, mrd, mwr, irw, rdst, m2r, rw, asa, asb, aop, done, ill};
  endfunction

  // One cycle: after the edge, drive inputs and queue what this cycle must show.
  task automatic step(input string tag, input logic r, input logic [5:0] op,
                      input logic mr, input logic [3:0] st);
    exp_t e;
    @(posedge clk);
    #1;
    rst            = r;
    bus.i_opcode   = op;
    bus.i_memReady = mr;
    e.tag = tag;
    e.exp = expect_vec(st, mr, op);
    q.push_back(e);
  endtask

  // Monitor: compares the live DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [21:0] act;
      e = q.pop_front();
      act = {bus.o_state, bus.o_pcWrite, bus.o_pcWriteCond, bus.o_pcSource, bus.o_iorD,
             bus.o_memRead, bus.o_memWrite, bus.o_irWrite, bus.o_regDst, bus.o_memToReg,
             bus.o_regWrite, bus.o_aluSrcA, bus.o_aluSrcB, bus.o_aluOp, bus.o_instrDone,
             bus.o_illegal};
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h (state got %0d expected %0d)",
                 e.tag, act, e.exp, act[21:18], e.exp[21:18]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bus.i_opcode   = 6'h00;
    bus.i_memReady = 1'b1;
    @(posedge clk);
    // Reset held across three edges, released with memReady high.
    step("rst_idle0", 1'b1, 6'h00, 1'b1, 4'd0);
    step("rst_idle1", 1'b0, 6'h00, 1'b1, 4'd0);
    // R-type: 1,2,7,8 (memReady ignored in EXEC).
    step("r_fetch",   1'b0, 6'h00, 1'b1, 4'd1);
    step("r_decode",  1'b0, 6'h00, 1'b1, 4'd2);
    step("r_exec",    1'b0, 6'h3F, 1'b0, 4'd7);
    step("r_aluwb",   1'b0, 6'h3F, 1'b1, 4'd8);
    // lw with two FETCH waits and one MEMRD wait; opcode garbage in MEMADR.
    step("lw_fetch0", 1'b0, 6'h23, 1'b0, 4'd1);
    step("lw_fetch1", 1'b0, 6'h23, 1'b0, 4'd1);
    step("lw_fetch2", 1'b0, 6'h23, 1'b1, 4'd1);
    step("lw_decode", 1'b0, 6'h23, 1'b1, 4'd2);
    step("lw_memadr", 1'b0, 6'h2B, 1'b0, 4'd3);
    step("lw_memrd0", 1'b0, 6'h2B, 1'b0, 4'd4);
    step("lw_memrd1", 1'b0, 6'h2B, 1'b1, 4'd4);
    step("lw_memwb",  1'b0, 6'h2B, 1'b0, 4'd5);
    // sw with one MEMWR wait; garbage opcode in MEMADR must not turn it into lw.
    step("sw_fetch",  1'b0, 6'h2B, 1'b1, 4'd1);
    step("sw_decode", 1'b0, 6'h2B, 1'b1, 4'd2);
    step("sw_memadr", 1'b0, 6'h23, 1'b1, 4'd3);
    step("sw_memwr0", 1'b0, 6'h23, 1'b0, 4'd6);
    step("sw_memwr1", 1'b0, 6'h23, 1'b1, 4'd6);
    // beq and j back-to-back.
    step("beq_fetch", 1'b0, 6'h04, 1'b1, 4'd1);
    step("beq_dec",   1'b0, 6'h04, 1'b1, 4'd2);
    step("beq_br",    1'b0, 6'h00, 1'b0, 4'd9);
    step("j_fetch",   1'b0, 6'h02, 1'b1, 4'd1);
    step("j_dec",     1'b0, 6'h02, 1'b1, 4'd2);
    step("j_jump",    1'b0, 6'h00, 1'b0, 4'd10);
    // addi.
    step("addi_fetch", 1'b0, 6'h08, 1'b1, 4'd1);
    step("addi_dec",   1'b0, 6'h08, 1'b1, 4'd2);
    step("addi_ex",    1'b0, 6'h00, 1'b0, 4'd11);
    step("addi_wb",    1'b0, 6'h00, 1'b0, 4'd12);
    // Illegal opcode: two cycles, back to FETCH.
    step("ill_fetch", 1'b0, 6'h3F, 1'b1, 4'd1);
    step("ill_dec",   1'b0, 6'h3F, 1'b1, 4'd2);
    // sw interrupted by reset while waiting in MEMWR.
    step("swr_fetch", 1'b0, 6'h2B, 1'b1, 4'd1);
    step("swr_dec",   1'b0, 6'h2B, 1'b1, 4'd2);
    step("swr_adr",   1'b0, 6'h2B, 1'b0, 4'd3);
    step("swr_wr",    1'b1, 6'h2B, 1'b0, 4'd6);
    step("swr_idle",  1'b0, 6'h2B, 1'b0, 4'd0);
    step("swr_refetch", 1'b0, 6'h00, 1'b0, 4'd1);
    step("swr_wait",    1'b0, 6'h00, 1'b1, 4'd1);
    step("swr_dec2",    1'b0, 6'h00, 1'b1, 4'd2);
    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
